// File: rtl/intr_ctrl_core.sv
// Interrupt controller core: per-source level/edge capture behind a small register map,
// with a registered request and lowest-index priority encoder.
module intr_ctrl_core #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IRQ    = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] PADDR_ip,
  input  logic [DATA_WIDTH-1:0] PWDATA_ip,
  input  logic                  write_en_ip,
  output logic [DATA_WIDTH-1:0] PRDATA_ip,
  input  logic [NUM_IRQ-1:0]    irq_src_i,
  output logic                  irq_o,
  output logic [5:0]            irq_id_o
);

  logic                 addr_ok;
  logic [2:0]           word_idx;
  logic                 wr_en_reg;
  logic                 wr_type_reg;
  logic                 wr_clr_reg;
  logic [NUM_IRQ-1:0]   wdata_irq;

  logic [NUM_IRQ-1:0]   irq_en;
  logic [NUM_IRQ-1:0]   irq_type;
  logic [NUM_IRQ-1:0]   pending;
  logic [NUM_IRQ-1:0]   s1, s2, s3;

  logic [NUM_IRQ-1:0]   type_next;
  logic [NUM_IRQ-1:0]   type_chg;
  logic [NUM_IRQ-1:0]   clr_mask;
  logic [NUM_IRQ-1:0]   edge_set;
  logic [NUM_IRQ-1:0]   pend_next;
  logic [NUM_IRQ-1:0]   active;
  logic [5:0]           id_next;
  logic [DATA_WIDTH-1:0] rd_data;

  assign addr_ok     = (PADDR_ip[ADDR_WIDTH-1:5] == '0) && (PADDR_ip[1:0] == 2'b00);
  assign word_idx    = PADDR_ip[4:2];
  assign wr_en_reg   = write_en_ip && addr_ok && (word_idx == 3'd0);
  assign wr_type_reg = write_en_ip && addr_ok && (word_idx == 3'd1);
  assign wr_clr_reg  = write_en_ip && addr_ok && (word_idx == 3'd3);
  assign wdata_irq   = PWDATA_ip[NUM_IRQ-1:0];

  assign type_next = wr_type_reg ? wdata_irq : irq_type;
  assign type_chg  = irq_type ^ type_next;
  assign clr_mask  = wr_clr_reg ? wdata_irq : '0;
  assign edge_set  = s2 & ~s3;

  // Edge bits: sticky until cleared, a coincident new edge beats the clear.
  // Any bit whose type is being rewritten restarts from zero.
  assign pend_next = ~type_chg &
                     ((irq_type & ((pending & ~clr_mask) | edge_set)) |
                      (~irq_type & s2));

  assign active = pending & irq_en;

  always_comb begin
    id_next = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) id_next = 6'(i);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irq_en   <= '0;
      irq_type <= '0;
      pending  <= '0;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else begin
      s1       <= irq_src_i;
      s2       <= s1;
      s3       <= s2;
      pending  <= pend_next;
      irq_type <= type_next;
      if (wr_en_reg) irq_en <= wdata_irq;
      irq_o    <= |active;
      irq_id_o <= id_next;
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr_ok) begin
      case (word_idx)
        3'd0: rd_data[NUM_IRQ-1:0] = irq_en;
        3'd1: rd_data[NUM_IRQ-1:0] = irq_type;
        3'd2: rd_data[NUM_IRQ-1:0] = pending;
        3'd4: begin
          rd_data[31]  = irq_o;
          rd_data[5:0] = irq_id_o;
        end
        default: rd_data = '0;
      endcase
    end
  end

  assign PRDATA_ip = rd_data;

endmodule

// File: tb/tb_intr_ctrl_core.sv
// Directed bench for intr_ctrl_core: register-map vector table followed by
// hand-written interrupt capture, clear, priority and reset sequences.
module tb_intr_ctrl_core;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        we;
  logic [31:0] PRDATA;
  logic [31:0] src;
  logic        irq;
  logic [5:0]  id;

  int total = 0;
  int bad   = 0;

  intr_ctrl_core #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_IRQ(32)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .PADDR_ip   (PADDR),
    .PWDATA_ip  (PWDATA),
    .write_en_ip(we),
    .PRDATA_ip  (PRDATA),
    .irq_src_i  (src),
    .irq_o      (irq),
    .irq_id_o   (id)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    PADDR  = addr;
    PWDATA = data;
    we     = 1'b1;
    tick();
    we     = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    PADDR = addr;
    #1;
    chk(name, PRDATA, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp_irq, input logic [5:0] exp_id);
    chk({name, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
    chk({name, "_id"}, {26'd0, id}, {26'd0, exp_id});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'h00, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{32'h04, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{32'h08, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{32'h0C, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{32'h10, 32'h0,        1'b0, 32'h0};
    vecs[5]  = '{32'h00, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5};
    vecs[6]  = '{32'h04, 32'h0000F00F, 1'b1, 32'h0000F00F};
    vecs[7]  = '{32'h0C, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[8]  = '{32'h08, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[9]  = '{32'h10, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[10] = '{32'h14, 32'h12345678, 1'b1, 32'h0};
    vecs[11] = '{32'h02, 32'h12345678, 1'b1, 32'h0};
    vecs[12] = '{32'h00, 32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[13] = '{32'h20, 32'h0,        1'b1, 32'h0};
    vecs[14] = '{32'h00, 32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[15] = '{32'h01, 32'h0,        1'b1, 32'h0};
    vecs[16] = '{32'h04, 32'h0,        1'b0, 32'h0000F00F};
    vecs[17] = '{32'h04, 32'h0,        1'b1, 32'h0};
    vecs[18] = '{32'h00, 32'h0,        1'b1, 32'h0};

    PRESET = 1'b1;
    PADDR  = '0;
    PWDATA = '0;
    we     = 1'b0;
    src    = '0;
    repeat (3) tick();
    irq_chk("reset", 1'b0, 6'd0);
    PRESET = 1'b0;
    tick();

    // register map table
    for (int i = 0; i < 19; i++) begin
      PADDR  = vecs[i].addr;
      PWDATA = vecs[i].wdata;
      we     = vecs[i].we;
      tick();
      we = 1'b0;
      chk($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), PRDATA, vecs[i].exp_rd);
    end
    irq_chk("after_table", 1'b0, 6'd0);

    // level source 4: pending two edges after sampling, irq one more
    wr(32'h00, 32'h10);
    wr(32'h04, 32'h0);
    src[4] = 1'b1;
    repeat (3) tick();
    rd_chk("lvl_status", 32'h08, 32'h10);
    irq_chk("lvl_k2", 1'b0, 6'd0);
    tick();
    irq_chk("lvl_k3", 1'b1, 6'd4);
    rd_chk("lvl_info", 32'h10, 32'h80000004);
    src[4] = 1'b0;
    repeat (3) tick();
    rd_chk("lvl_drop_status", 32'h08, 32'h0);
    tick();
    irq_chk("lvl_drop", 1'b0, 6'd0);

    // edge source 0: one-cycle pulse is sticky until cleared
    wr(32'h04, 32'h1);
    wr(32'h00, 32'h1);
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    repeat (2) tick();
    rd_chk("edge_set", 32'h08, 32'h1);
    repeat (3) tick();
    rd_chk("edge_sticky", 32'h08, 32'h1);
    irq_chk("edge_irq", 1'b1, 6'd0);
    wr(32'h0C, 32'h1);
    rd_chk("edge_clr_status", 32'h08, 32'h0);
    tick();
    irq_chk("edge_clr", 1'b0, 6'd0);

    // edge source 3: clear in the detect cycle loses to the set
    wr(32'h04, 32'h8);
    wr(32'h00, 32'h8);
    src[3] = 1'b1;
    repeat (2) tick();
    PADDR  = 32'h0C;
    PWDATA = 32'h8;
    we     = 1'b1;
    tick();
    we = 1'b0;
    rd_chk("set_wins", 32'h08, 32'h8);
    repeat (2) tick();
    irq_chk("set_wins", 1'b1, 6'd3);
    wr(32'h0C, 32'h8);
    rd_chk("clr_after_set", 32'h08, 32'h0);
    src[3] = 1'b0;
    repeat (4) tick();

    // priority between edge sources 2 and 7
    wr(32'h04, 32'h84);
    wr(32'h00, 32'h84);
    src[2] = 1'b1;
    src[7] = 1'b1;
    repeat (4) tick();
    rd_chk("prio_status", 32'h08, 32'h84);
    irq_chk("prio_both", 1'b1, 6'd2);
    wr(32'h0C, 32'h4);
    rd_chk("prio_clr2", 32'h08, 32'h80);
    tick();
    irq_chk("prio_7", 1'b1, 6'd7);
    // changing bit 7 to level drops it that cycle, then it follows the source
    wr(32'h04, 32'h04);
    rd_chk("type_chg_clr", 32'h08, 32'h0);
    tick();
    rd_chk("type_lvl_follow", 32'h08, 32'h80);
    wr(32'h00, 32'h0);
    tick();
    irq_chk("en_off", 1'b0, 6'd0);

    // reset with a coincident write; sources 2 and 7 stay high
    PADDR  = 32'h00;
    PWDATA = 32'hFF;
    we     = 1'b1;
    PRESET = 1'b1;
    tick();
    we     = 1'b0;
    PRESET = 1'b0;
    rd_chk("rst_en", 32'h00, 32'h0);
    rd_chk("rst_status", 32'h08, 32'h0);
    irq_chk("rst_mid", 1'b0, 6'd0);
    wr(32'h04, 32'h84);
    rd_chk("post_rst_e1", 32'h08, 32'h0);
    tick();
    rd_chk("post_rst_e2", 32'h08, 32'h0);
    tick();
    rd_chk("post_rst_e3", 32'h08, 32'h84);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intr_ctrl_core.md
INTR_CTRL_CORE -- requirements
Module: intr_ctrl_core

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, register-port address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width (fixed 32; other values unsupported).
REQ-003 SHALL have parameter NUM_IRQ, default 32, number of interrupt sources, legal range 1..32.
REQ-004 SHALL have port PCLK, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 SHALL have port PRESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port PADDR_ip, input, ADDR_WIDTH bits: byte address from the APB slave.
REQ-007 SHALL have port PWDATA_ip, input, DATA_WIDTH bits: write data, already strobe-merged with current read data.
REQ-008 SHALL have port write_en_ip, input, 1 bit: one-cycle write qualifier, asserted only for aligned, in-range addresses.
REQ-009 SHALL have port PRDATA_ip, output, DATA_WIDTH bits: combinational read data for PADDR_ip.
REQ-010 SHALL have port irq_src_i, input, NUM_IRQ bits: asynchronous interrupt sources.
REQ-011 SHALL have port irq_o, output, 1 bit: registered interrupt request.
REQ-012 SHALL have port irq_id_o, output, 6 bits: registered index of the lowest-numbered enabled pending source.

Function
REQ-013 SHALL decode only when PADDR_ip[ADDR_WIDTH-1:5]==0 and PADDR_ip[1:0]==0; word index PADDR_ip[4:2].
REQ-014 SHALL map 0x00 IRQ_EN (RW), 0x04 IRQ_TYPE (RW, 1=rising edge, 0=level-high), 0x08 IRQ_STATUS (RO, pending), 0x0C IRQ_CLR (WO, reads 0), 0x10 IRQ_INFO (RO: bit31=irq_o, bits[5:0]=irq_id_o).
REQ-015 SHALL return 0 for unmapped or unaligned reads and ignore writes to them and to RO registers.
REQ-016 SHALL read bits [31:NUM_IRQ] of IRQ_EN/IRQ_TYPE/IRQ_STATUS as 0 and ignore writes to them.
REQ-017 SHALL make IRQ_CLR read 0, so that strobe-merged unwritten bytes never clear status.
REQ-018 SHALL synchronize each irq_src_i bit through two flops (s1, s2) and keep a delayed copy s3 for edge detection.
REQ-019 Level source (TYPE=0): pending SHALL equal s2 each cycle; IRQ_CLR has no effect.
REQ-020 Edge source (TYPE=1): pending SHALL set when s2 & ~s3, and stay set until a 1 is written to its IRQ_CLR bit.
REQ-021 Simultaneous edge-set and IRQ_CLR on the same bit SHALL leave pending set (set wins).
REQ-022 A write to IRQ_TYPE SHALL clear pending for every bit whose type changes, in the same cycle.
REQ-023 Latency: source rising before edge k SHALL produce pending after edge k+2 and irq_o after edge k+3.
REQ-024 irq_o SHALL be registered |(pending & IRQ_EN[NUM_IRQ-1:0]); irq_id_o registered lowest set index of that vector, 0 when none.
REQ-025 A write to IRQ_EN SHALL affect irq_o from the next edge (one-cycle registered update).
REQ-026 PRDATA_ip SHALL reflect register contents combinationally, including updates made at the previous edge.

Reset
REQ-027 While PRESET is high at a rising edge, IRQ_EN, IRQ_TYPE, pending, s1, s2, s3, irq_o, irq_id_o SHALL all be 0.
REQ-028 Reset mid-operation SHALL discard pending edges and writes in that cycle; the first cycle after reset is idle.
REQ-029 The first rising edge on an already-high source after reset SHALL be detected no earlier than 2 cycles after reset release.

Verification
REQ-030 Reset, then read 0x00..0x10 -> all return 0x00000000; irq_o=0, irq_id_o=0.
REQ-031 Write IRQ_EN=0x00000010, IRQ_TYPE=0; raise irq_src_i[4] before edge k -> STATUS=0x10 after k+2, irq_o=1 and irq_id_o=4 after k+3; drop the source -> irq_o=0 three edges later.
REQ-032 IRQ_TYPE=0x1, IRQ_EN=0x1, pulse irq_src_i[0] one cycle -> STATUS bit0 sticky; write IRQ_CLR=0x1 -> STATUS=0, irq_o=0 next edge.
REQ-033 Edge source bit3: write IRQ_CLR=0x8 in the same cycle the set detects an edge -> STATUS bit3 remains 1.
REQ-034 Sources 2 and 7 pending, IRQ_EN=0x84 -> irq_id_o=2; clear bit2 -> irq_id_o=7; IRQ_EN=0 -> irq_o=0, irq_id_o=0.
REQ-035 Write 0x14 and 0x02 with write_en_ip asserted -> no register changes; reads of those addresses return 0.
